// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDstall = 2'd1,
        StIstall = 2'd2,
        StRedir  = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
    parameter int unsigned CNT_W = pipe_ctrl_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller with saturating performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_haz_nop,
    input  logic             i_branch_taken_A,
    input  logic             i_imem_busy,
    input  logic             i_dmem_busy,
    input  logic             i_cnt_clr,
    output logic             o_en_F,
    output logic             o_en_D,
    output logic             o_en_A,
    output logic             o_en_M,
    output logic             o_flush_D,
    output logic             o_flush_A,
    output logic             o_bubble_W,
    output logic             o_redirect,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cnt_cycles,
    output logic [CNT_W-1:0] o_cnt_stall,
    output logic [CNT_W-1:0] o_cnt_flush
);

    state_e state_q, state_d;

    // Outputs are combinational so a stall takes effect the cycle it is raised.
    always_comb begin
        o_en_F     = 1'b1;
        o_en_D     = 1'b1;
        o_en_A     = 1'b1;
        o_en_M     = 1'b1;
        o_flush_D  = 1'b0;
        o_flush_A  = 1'b0;
        o_bubble_W = 1'b0;
        o_redirect = 1'b0;
        state_d    = StRun;

        if (rst) begin
            o_en_F     = 1'b0;
            o_en_D     = 1'b0;
            o_en_A     = 1'b0;
            o_en_M     = 1'b0;
            o_flush_D  = 1'b1;
            o_flush_A  = 1'b1;
            o_bubble_W = 1'b1;
        end else if (i_dmem_busy) begin
            o_en_F     = 1'b0;
            o_en_D     = 1'b0;
            o_en_A     = 1'b0;
            o_en_M     = 1'b0;
            o_bubble_W = 1'b1;
            state_d    = StDstall;
        end else if (i_branch_taken_A) begin
            o_flush_D  = 1'b1;
            o_flush_A  = 1'b1;
            o_redirect = 1'b1;
            state_d    = StRedir;
        end else if (state_q == StRedir) begin
            // Fetch issued during the redirect is wrong-path; hazards are moot.
            o_flush_D = 1'b1;
            if (i_imem_busy) begin
                o_en_F  = 1'b0;
                state_d = StIstall;
            end
        end else if (i_haz_nop) begin
            o_en_F    = 1'b0;
            o_en_D    = 1'b0;
            o_flush_A = 1'b1;
            state_d   = i_imem_busy ? StIstall : StRun;
        end else if (i_imem_busy) begin
            o_en_F    = 1'b0;
            o_flush_D = 1'b1;
            state_d   = StIstall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

    logic cnt_clr;
    assign cnt_clr = rst | i_cnt_clr;

    sat_cnt #(.CNT_W(CNT_W)) u_cnt_cycles (
        .clk   (clk),
        .clr   (cnt_clr),
        .inc   (1'b1),
        .count (o_cnt_cycles)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .clr   (cnt_clr),
        .inc   (~o_en_D),
        .count (o_cnt_stall)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .clr   (cnt_clr),
        .inc   (o_redirect),
        .count (o_cnt_flush)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues expected outputs, negedge monitor checks.
module tb_pipe_ctrl;

    localparam int unsigned CW = 4;

    // {en_F, en_D, en_A, en_M, flush_D, flush_A, bubble_W, redirect}
    localparam logic [7:0] C_RST   = 8'b0000_1110;
    localparam logic [7:0] C_NORM  = 8'b1111_0000;
    localparam logic [7:0] C_HAZ   = 8'b0011_0100;
    localparam logic [7:0] C_BR    = 8'b1111_1101;
    localparam logic [7:0] C_DM    = 8'b0000_0010;
    localparam logic [7:0] C_REDIR = 8'b1111_1000;
    localparam logic [7:0] C_IMEM  = 8'b0111_1000;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_DST = 2'd1;
    localparam logic [1:0] S_IST = 2'd2;
    localparam logic [1:0] S_RED = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic haz = 1'b0, br = 1'b0, imem = 1'b0, dmem = 1'b0, clr = 1'b0;
    logic en_f, en_d, en_a, en_m, fl_d, fl_a, bub_w, redir;
    logic [1:0]    state;
    logic [CW-1:0] cnt_cyc, cnt_stl, cnt_fls;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_haz_nop        (haz),
        .i_branch_taken_A (br),
        .i_imem_busy      (imem),
        .i_dmem_busy      (dmem),
        .i_cnt_clr        (clr),
        .o_en_F           (en_f),
        .o_en_D           (en_d),
        .o_en_A           (en_a),
        .o_en_M           (en_m),
        .o_flush_D        (fl_d),
        .o_flush_A        (fl_a),
        .o_bubble_W       (bub_w),
        .o_redirect       (redir),
        .o_state          (state),
        .o_cnt_cycles     (cnt_cyc),
        .o_cnt_stall      (cnt_stl),
        .o_cnt_flush      (cnt_fls)
    );

    typedef struct {
        string         name;
        logic [7:0]    ctrl;
        logic [1:0]    st;
        logic [CW-1:0] cyc;
        logic [CW-1:0] stl;
        logic [CW-1:0] fls;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    logic [CW-1:0] m_cyc = '0, m_stl = '0, m_fls = '0;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, fld, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "ctrl", 32'({en_f, en_d, en_a, en_m, fl_d, fl_a, bub_w, redir}),
                32'(e.ctrl));
            chk(e.name, "state", 32'(state), 32'(e.st));
            chk(e.name, "cnt_cycles", 32'(cnt_cyc), 32'(e.cyc));
            chk(e.name, "cnt_stall", 32'(cnt_stl), 32'(e.stl));
            chk(e.name, "cnt_flush", 32'(cnt_fls), 32'(e.fls));
        end
    end

    // One cycle: apply inputs, queue the expectation, then advance the counter model.
    task automatic step(input string nm, input logic r, input logic h, input logic b,
                        input logic im, input logic dm, input logic c,
                        input logic [7:0] ctrl, input logic [1:0] st);
        exp_t e;
        rst  = r;
        haz  = h;
        br   = b;
        imem = im;
        dmem = dm;
        clr  = c;
        e.name = nm;
        e.ctrl = ctrl;
        e.st   = st;
        e.cyc  = m_cyc;
        e.stl  = m_stl;
        e.fls  = m_fls;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (r || c) begin
            m_cyc = '0;
            m_stl = '0;
            m_fls = '0;
        end else begin
            m_cyc = sat_inc(m_cyc);
            if (!ctrl[6]) m_stl = sat_inc(m_stl);
            if (ctrl[0])  m_fls = sat_inc(m_fls);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("reset0", 1, 0, 0, 0, 0, 0, C_RST, S_RUN);
        step("reset1", 1, 1, 1, 1, 1, 0, C_RST, S_RUN);
        step("idle0",  0, 0, 0, 0, 0, 0, C_NORM, S_RUN);
        step("idle1",  0, 0, 0, 0, 0, 0, C_NORM, S_RUN);

        step("haz",      0, 1, 0, 0, 0, 0, C_HAZ, S_RUN);
        step("haz_post", 0, 0, 0, 0, 0, 0, C_NORM, S_RUN);

        step("br",      0, 0, 1, 0, 0, 0, C_BR, S_RUN);
        step("br_n1",   0, 0, 0, 0, 0, 0, C_REDIR, S_RED);
        step("br_n2",   0, 0, 0, 0, 0, 0, C_NORM, S_RUN);
        step("br2",     0, 0, 1, 0, 0, 0, C_BR, S_RUN);
        step("red_haz", 0, 1, 0, 0, 0, 0, C_REDIR, S_RED);
        step("red_out", 0, 0, 0, 0, 0, 0, C_NORM, S_RUN);
        step("br3",     0, 0, 1, 0, 0, 0, C_BR, S_RUN);
        step("red_im",  0, 0, 0, 1, 0, 0, C_IMEM, S_RED);
        step("red_ist", 0, 0, 0, 0, 0, 0, C_NORM, S_IST);
        step("red_run", 0, 0, 0, 0, 0, 1, C_NORM, S_RUN);

        step("dm0",    0, 1, 1, 0, 1, 0, C_DM, S_RUN);
        step("dm1",    0, 1, 1, 0, 1, 0, C_DM, S_DST);
        step("dm2",    0, 1, 1, 0, 1, 0, C_DM, S_DST);
        step("dm_rel", 0, 1, 1, 0, 0, 0, C_BR, S_DST);
        step("dm_red", 0, 0, 0, 0, 0, 0, C_REDIR, S_RED);
        step("dm_run", 0, 0, 0, 0, 0, 0, C_NORM, S_RUN);

        step("im0",     0, 0, 0, 1, 0, 0, C_IMEM, S_RUN);
        step("im1",     0, 0, 0, 1, 0, 0, C_IMEM, S_IST);
        step("im2",     0, 0, 0, 1, 0, 0, C_IMEM, S_IST);
        step("im3",     0, 0, 0, 1, 0, 0, C_IMEM, S_IST);
        step("im_rel",  0, 0, 0, 0, 0, 0, C_NORM, S_IST);
        step("im_run",  0, 0, 0, 0, 0, 0, C_NORM, S_RUN);
        step("haz_im",  0, 1, 0, 1, 0, 0, C_HAZ, S_RUN);
        step("haz_ist", 0, 0, 0, 0, 0, 1, C_NORM, S_IST);

        for (int i = 0; i < 20; i++) begin
            step("sat", 0, 1, 0, 0, 0, 0, C_HAZ, S_RUN);
        end
        step("sat_clr",  0, 1, 0, 0, 0, 1, C_HAZ, S_RUN);
        step("post_clr", 0, 0, 0, 0, 0, 0, C_NORM, S_RUN);

        step("rbr",      0, 0, 1, 0, 0, 0, C_BR, S_RUN);
        step("rst_red",  1, 0, 1, 1, 0, 0, C_RST, S_RED);
        step("rst_rel",  0, 0, 0, 0, 0, 0, C_NORM, S_RUN);
        step("rdm",      0, 0, 0, 0, 1, 0, C_DM, S_RUN);
        step("rst_dst",  1, 0, 0, 0, 1, 0, C_RST, S_DST);
        step("rst_rel2", 0, 0, 0, 0, 0, 0, C_NORM, S_RUN);
        step("tail",     0, 0, 0, 0, 0, 0, C_NORM, S_RUN);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
